// File: rtl/vga_pkg.sv
// Shared VGA adapter constants and the plot-arbiter state type.
package vga_pkg;

  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible index after `last`, wrapping.
module rr_pick #(
  parameter int N    = 3,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [IDXW-1:0] last,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] w_cand;

  // Scanning from the farthest offset down lets the nearest eligible client win.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IDXW'((int'(last) + k) % N);
      if (eligible[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA plot port, shared by the drawing engines.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter  int N    = 3,
  localparam int IDXW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      cl_done,
  input  logic [XW*N-1:0]   cl_x,
  input  logic [YW*N-1:0]   cl_y,
  input  logic [CW*N-1:0]   cl_colour,
  input  logic [N-1:0]      cl_plot,
  output logic [N-1:0]      cl_start,
  output logic [XW-1:0]     vga_x,
  output logic [YW-1:0]     vga_y,
  output logic [CW-1:0]     vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic [IDXW-1:0]   grant_idx
);

  arb_state_t      r_state, w_state_nxt;
  logic [IDXW-1:0] r_last, w_last_nxt;
  logic [IDXW-1:0] r_grant_idx, w_grant_nxt;
  logic [N-1:0]    w_eligible;
  logic            w_found;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_cl_done, w_cl_req, w_pass;

  assign w_eligible = req & ~cl_done;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .eligible (w_eligible),
    .last     (r_last),
    .found    (w_found),
    .idx      (w_pick_idx)
  );

  assign w_cl_done = cl_done[r_grant_idx];
  assign w_cl_req  = req[r_grant_idx];
  // The cycle that ends a grant (done or abort) forwards nothing.
  assign w_pass    = (r_state == GRANT) && w_cl_req && !w_cl_done;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant_idx;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_cl_done) begin
          w_last_nxt  = r_grant_idx;
          w_state_nxt = RELEASE;
        end else if (!w_cl_req) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= IDXW'(N - 1);
      r_grant_idx <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_grant_idx <= w_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= w_pass & cl_plot[r_grant_idx];
      if (w_pass) begin
        vga_x      <= cl_x[XW*int'(r_grant_idx) +: XW];
        vga_y      <= cl_y[YW*int'(r_grant_idx) +: YW];
        vga_colour <= cl_colour[CW*int'(r_grant_idx) +: CW];
      end
    end
  end

  always_comb begin
    cl_start = '0;
    if (r_state == GRANT) cl_start[r_grant_idx] = 1'b1;
  end

  assign busy      = (r_state == GRANT);
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed and random checks of vga_plot_arbiter against a grant/owner reference model.
module tb_vga_plot_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, cl_done = '0, cl_plot = '0;
  logic [23:0] cl_x = '0;
  logic [20:0] cl_y = '0;
  logic [8:0]  cl_colour = '0;
  logic [2:0]  cl_start;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;
  logic [1:0]  grant_idx;

  vga_plot_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cl_done(cl_done), .cl_x(cl_x), .cl_y(cl_y),
    .cl_colour(cl_colour), .cl_plot(cl_plot), .cl_start(cl_start), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0, bad = 0;

  // Reference model: owner (-1 = nobody), dead cycles left, pointer, held pixel.
  int         m_owner, m_cool, m_last, m_gidx;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  logic       m_plot;

  // Client emulation and grant-order bookkeeping.
  bit auto_cl = 0, force0 = 0;
  int run_cnt [N];
  int order[$], gaps[$];
  int zero_run = 0;
  logic [2:0] prev_start = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cool = 0; m_last = N - 1; m_gidx = 0;
    m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;
    for (int i = 0; i < N; i++) run_cnt[i] = 0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      if (cl_done[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_cool = 1; m_plot = 1'b0;
      end else if (!req[m_owner]) begin
        m_owner = -1; m_cool = 1; m_plot = 1'b0;
      end else begin
        m_x = cl_x[8*m_owner +: 8];
        m_y = cl_y[7*m_owner +: 7];
        m_c = cl_colour[3*m_owner +: 3];
        m_plot = cl_plot[m_owner];
      end
    end else if (m_cool > 0) begin
      m_cool--; m_plot = 1'b0;
    end else begin
      m_plot = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (req[j] && !cl_done[j]) begin
          m_owner = j; m_gidx = j;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] e_start;
    e_start = '0;
    if (m_owner >= 0) e_start[m_owner] = 1'b1;
    check("cl_start", 32'(cl_start), 32'(e_start));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("grant_idx", 32'(grant_idx), 32'(m_gidx));
    check("vga_plot", 32'(vga_plot), 32'(m_plot));
    check("vga_x", 32'(vga_x), 32'(m_x));
    check("vga_y", 32'(vga_y), 32'(m_y));
    check("vga_colour", 32'(vga_colour), 32'(m_c));
  endtask

  function automatic int onehot_idx(input logic [2:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // A client finishes on its fourth cycle of start and drops done once start falls.
  task automatic client_drive();
    for (int i = 0; i < N; i++) begin
      if (cl_start[i]) begin
        run_cnt[i]++;
        cl_done[i] = (run_cnt[i] >= 4);
      end else begin
        run_cnt[i] = 0;
        cl_done[i] = 1'b0;
      end
    end
    if (force0) cl_done[0] = 1'b1;
  endtask

  task automatic tick();
    if (auto_cl) client_drive();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (cl_start != 3'b000) begin
      if (prev_start == 3'b000) begin
        order.push_back(onehot_idx(cl_start));
        gaps.push_back(zero_run);
      end
      zero_run = 0;
    end else begin
      zero_run++;
    end
    prev_start = cl_start;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    order.delete(); gaps.delete();
    zero_run = 0; prev_start = '0;
  endtask

  initial begin
    int exp_order [4];
    bit found0;

    // Reset with all requests pending, then round robin with 4-cycle clients.
    req = 3'b111;
    #2;
    apply_reset();
    check("rst_start", 32'(cl_start), 32'd0);
    auto_cl = 1;
    tick();
    check("first_grant", 32'(cl_start), 32'(3'b001));
    for (int c = 0; c < 26; c++) tick();
    exp_order = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++)
      check("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    for (int i = 1; i < 4; i++)
      check("rr_gap", (i < gaps.size()) ? 32'(gaps[i]) : 32'hFFFF_FFFF, 32'd2);
    auto_cl = 0;

    // Single client pixel path and done release.
    req = 3'b000; cl_done = '0;
    apply_reset();
    req = 3'b010;
    cl_x = {8'd77, 8'd5, 8'd66};
    cl_y = {7'd44, 7'd7, 7'd33};
    cl_colour = {3'd6, 3'd3, 3'd5};
    cl_plot = 3'b111;
    tick();
    check("single_start", 32'(cl_start), 32'(3'b010));
    tick();
    check("single_x", 32'(vga_x), 32'd5);
    check("single_y", 32'(vga_y), 32'd7);
    check("single_col", 32'(vga_colour), 32'd3);
    check("single_plot", 32'(vga_plot), 32'd1);
    cl_done = 3'b010;
    tick();
    check("single_done_start", 32'(cl_start), 32'd0);
    check("single_done_plot", 32'(vga_plot), 32'd0);
    cl_done = '0; req = '0; cl_plot = '0;
    tick(); tick();

    // Isolation: client 2 plots x=99 while client 0 holds the port.
    apply_reset();
    req = 3'b101;
    for (int c = 0; c < 12; c++) begin
      cl_x = {8'd99, 8'd0, 8'($urandom_range(90))};
      cl_plot = {1'b1, 1'b0, 1'($urandom_range(1))};
      tick();
      check("iso_x", 32'(vga_x != 8'd99), 32'd1);
    end
    cl_done = 3'b001;
    tick();
    cl_done = '0; req = '0; cl_plot = '0;

    // Sticky done on client 0: client 1 keeps winning until done falls.
    apply_reset();
    req = 3'b011; force0 = 1; auto_cl = 1;
    for (int c = 0; c < 40; c++) tick();
    check("sticky_cnt", 32'(order.size() >= 3), 32'd1);
    foreach (order[i]) check("sticky_only1", 32'(order[i]), 32'd1);
    force0 = 0; found0 = 0;
    for (int c = 0; c < 30 && !found0; c++) begin
      tick();
      if (cl_start == 3'b001) found0 = 1;
    end
    check("sticky_release", 32'(found0), 32'd1);
    auto_cl = 0; req = '0; cl_done = '0;

    // Abort by dropping req, then asynchronous reset mid-grant.
    apply_reset();
    req = 3'b010; cl_plot = 3'b010;
    cl_x = {8'd1, 8'd42, 8'd2};
    tick(); tick(); tick();
    check("abort_pre_plot", 32'(vga_plot), 32'd1);
    req = 3'b000;
    tick();
    check("abort_start", 32'(cl_start), 32'd0);
    check("abort_plot", 32'(vga_plot), 32'd0);
    req = 3'b010;
    tick(); tick();
    check("regrant", 32'(cl_start), 32'(3'b010));
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_start", 32'(cl_start), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_plot", 32'(vga_plot), 32'd0);
    check("async_x", 32'(vga_x), 32'd0);
    check_all();
    req = 3'b111; cl_plot = '0;
    apply_reset();
    tick();
    check("ptr_reset", 32'(cl_start), 32'(3'b001));

    // Random traffic against the reference model.
    req = '0;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]     = ($urandom_range(3) != 0);
        cl_done[i] = ($urandom_range(5) == 0);
        cl_plot[i] = 1'($urandom_range(1));
      end
      cl_x = 24'($urandom);
      cl_y = 21'($urandom);
      cl_colour = 9'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
